// File: rtl/rob_commit_unit_if.sv
// rob_commit_unit_if: issue, status-table, CDB, flush and commit signals
// of the reorder buffer, seen from the ROB (master) and its peers (slave).
interface rob_commit_unit_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_has_dest;
  logic [4:0]        issue_dest;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;

  logic              stat_we;
  logic [4:0]        stat_index;
  logic [5:0]        stat_data;
  logic [4:0]        stat_query_index;
  logic [5:0]        stat_query_data;
  logic              stat_clear_all;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;

  logic              flush;

  logic              commit_valid;
  logic              commit_has_dest;
  logic [4:0]        commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic [TAG_W-1:0]  commit_tag;

  modport master (
    input  issue_valid, issue_has_dest, issue_dest,
    input  stat_query_data,
    input  cdb_valid, cdb_tag, cdb_value,
    input  flush,
    output issue_ready, issue_tag,
    output stat_we, stat_index, stat_data,
    output stat_query_index, stat_clear_all,
    output commit_valid, commit_has_dest,
    output commit_dest, commit_value, commit_tag
  );

  modport slave (
    output issue_valid, issue_has_dest, issue_dest,
    output stat_query_data,
    output cdb_valid, cdb_tag, cdb_value,
    output flush,
    input  issue_ready, issue_tag,
    input  stat_we, stat_index, stat_data,
    input  stat_query_index, stat_clear_all,
    input  commit_valid, commit_has_dest,
    input  commit_dest, commit_value, commit_tag
  );
endinterface

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: circular reorder buffer that allocates tags at issue,
// captures CDB results, retires in order and maintains the status table.
module rob_commit_unit #(
  parameter int         DEPTH       = 16,
  parameter int         TAG_W       = 4,
  parameter int         DATA_W      = 32,
  parameter logic [5:0] INVALID_TAG = 6'b010000
) (
  input logic               clk,
  input logic               rst,
  rob_commit_unit_if.master bus
);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] ONE  = (TAG_W+1)'(1);

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  has_dest;
  logic [4:0]        dest  [DEPTH];
  logic [DATA_W-1:0] value [DEPTH];

  logic accept;
  logic iss_wr;
  logic ret_ok;
  logic need_clr;
  logic stall;
  logic retire;

  always_comb begin
    bus.issue_ready      = (count != FULL);
    bus.issue_tag        = tail;
    bus.stat_query_index = dest[head];
    accept   = bus.issue_valid & bus.issue_ready;
    iss_wr   = accept & bus.issue_has_dest & ~bus.flush;
    ret_ok   = busy[head] & done[head];
    need_clr = ret_ok & has_dest[head] & ~bus.flush
             & (bus.stat_query_data == 6'(head));
    // single write port: issue wins, clear retries unless same reg
    stall    = iss_wr & need_clr & (bus.issue_dest != dest[head]);
    retire   = ret_ok & ~stall & ~bus.flush;
    bus.stat_we    = iss_wr | need_clr;
    bus.stat_index = '0;
    bus.stat_data  = INVALID_TAG;
    if (iss_wr) begin
      bus.stat_index = bus.issue_dest;
      bus.stat_data  = 6'(tail);
    end else if (need_clr) begin
      bus.stat_index = dest[head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      busy                <= '0;
      done                <= '0;
      has_dest            <= '0;
      for (int i = 0; i < DEPTH; i++) dest[i] <= '0;
      bus.stat_clear_all  <= 1'b0;
      bus.commit_valid    <= 1'b0;
      bus.commit_has_dest <= 1'b0;
      bus.commit_dest     <= '0;
      bus.commit_value    <= '0;
      bus.commit_tag      <= '0;
    end else begin
      bus.stat_clear_all <= bus.flush;
      bus.commit_valid   <= retire;
      if (retire) begin
        bus.commit_has_dest <= has_dest[head];
        bus.commit_dest     <= dest[head];
        bus.commit_value    <= value[head];
        bus.commit_tag      <= head;
      end
      if (bus.flush) begin
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (bus.cdb_valid && busy[bus.cdb_tag])
          done[bus.cdb_tag] <= 1'b1;
        if (retire) begin
          busy[head] <= 1'b0;
          head       <= head + TAG_W'(1);
        end
        if (accept) begin
          busy[tail]     <= 1'b1;
          done[tail]     <= 1'b0;
          has_dest[tail] <= bus.issue_has_dest;
          dest[tail]     <= bus.issue_dest;
          tail           <= tail + TAG_W'(1);
        end
        unique case ({accept, retire})
          2'b10:   count <= count + ONE;
          2'b01:   count <= count - ONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.flush && bus.cdb_valid && busy[bus.cdb_tag])
      value[bus.cdb_tag] <= bus.cdb_value;
  end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed stimulus, queue-level ROB model and a model
// status table that answers the ROB's head query.
module tb_rob_commit_unit;
  localparam logic [5:0] INV = 6'b010000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_commit_unit_if #(.TAG_W(4), .DATA_W(32)) b ();
  rob_commit_unit dut (.clk(clk), .rst(rst), .bus(b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // environment: register-status table
  logic [5:0] tbl [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tbl[i] <= INV;
    end else begin
      if (b.stat_clear_all)
        for (int i = 0; i < 32; i++) tbl[i] <= INV;
      if (b.stat_we) tbl[b.stat_index] <= b.stat_data;
    end
  end
  assign b.stat_query_data = tbl[b.stat_query_index];

  // model: in-flight entries in program order
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          hd;
    bit          dn;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  int   mtail = 0;
  bit   ecv   = 0;
  bit   eclr  = 0;
  ent_t ec;

  always @(negedge clk) begin
    bit         acc, ok, clr, iw, stall, ret, ewe;
    logic [4:0] eidx;
    logic [5:0] edat;
    if (rst) begin
      q.delete();
      mtail = 0;
      ecv   = 0;
      eclr  = 0;
    end else begin
      check("commit_valid", 32'(b.commit_valid), 32'(ecv));
      if (ecv) begin
        check("commit_dest", 32'(b.commit_dest), 32'(ec.dest));
        check("commit_value", b.commit_value, ec.val);
        check("commit_tag", 32'(b.commit_tag), 32'(ec.tag));
        check("commit_has_dest", 32'(b.commit_has_dest), 32'(ec.hd));
      end
      check("stat_clear_all", 32'(b.stat_clear_all), 32'(eclr));
      acc = b.issue_valid && (q.size() < 16);
      check("issue_ready", 32'(b.issue_ready), 32'(q.size() < 16));
      check("issue_tag", 32'(b.issue_tag), 32'(mtail));
      ok  = 0;
      clr = 0;
      if (q.size() > 0) begin
        ok  = q[0].dn;
        clr = ok && q[0].hd && (tbl[q[0].dest] == 6'(q[0].tag));
        check("stat_query_index", 32'(b.stat_query_index), 32'(q[0].dest));
      end
      iw   = acc && b.issue_has_dest && !b.flush;
      clr  = clr && !b.flush;
      ewe  = iw || clr;
      eidx = 5'd0;
      edat = INV;
      if (iw) begin
        eidx = b.issue_dest;
        edat = 6'(mtail);
      end else if (clr) begin
        eidx = q[0].dest;
      end
      check("stat_we", 32'(b.stat_we), 32'(ewe));
      check("stat_index", 32'(b.stat_index), 32'(eidx));
      check("stat_data", 32'(b.stat_data), 32'(edat));
      stall = iw && clr && (b.issue_dest != q[0].dest);
      ret   = ok && !stall && !b.flush;
      if (b.flush) begin
        q.delete();
        mtail = 0;
        ecv   = 0;
        eclr  = 1;
      end else begin
        eclr = 0;
        ecv  = ret;
        if (ret) ec = q.pop_front();
        if (b.cdb_valid)
          foreach (q[i])
            if (q[i].tag == int'(b.cdb_tag)) begin
              q[i].dn  = 1;
              q[i].val = b.cdb_value;
            end
        if (acc) begin
          q.push_back('{mtail, b.issue_dest, b.issue_has_dest, 1'b0, 32'd0});
          mtail = (mtail + 1) % 16;
        end
      end
    end
  end

  // stimulus
  logic       s_ready;
  logic       s_we;
  logic [3:0] s_tag;
  logic [4:0] s_idx;
  logic [5:0] s_data;

  task automatic cyc(bit iv = 0, bit hd = 0, logic [4:0] d = 0,
                     bit cv = 0, logic [3:0] ct = 0,
                     logic [31:0] val = 0, bit fl = 0);
    b.issue_valid    = iv;
    b.issue_has_dest = hd;
    b.issue_dest     = d;
    b.cdb_valid      = cv;
    b.cdb_tag        = ct;
    b.cdb_value      = val;
    b.flush          = fl;
    @(negedge clk);
    #1;
    s_ready = b.issue_ready;
    s_we    = b.stat_we;
    s_tag   = b.issue_tag;
    s_idx   = b.stat_index;
    s_data  = b.stat_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    b.issue_valid    = 1'b0;
    b.issue_has_dest = 1'b0;
    b.issue_dest     = '0;
    b.cdb_valid      = 1'b0;
    b.cdb_tag        = '0;
    b.cdb_value      = '0;
    b.flush          = 1'b0;
    @(negedge clk);
    #1;
    check("rst_commit_valid", 32'(b.commit_valid), 32'd0);
    check("rst_stat_we", 32'(b.stat_we), 32'd0);
    check("rst_stat_index", 32'(b.stat_index), 32'd0);
    check("rst_stat_data", 32'(b.stat_data), 32'(INV));
    check("rst_clear_all", 32'(b.stat_clear_all), 32'd0);
    check("rst_issue_tag", 32'(b.issue_tag), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // single instruction: issue, complete, retire with clear
    cyc(.iv(1), .hd(1), .d(5));
    check("s1_tag", 32'(s_tag), 32'd0);
    check("s1_we", 32'(s_we), 32'd1);
    check("s1_idx", 32'(s_idx), 32'd5);
    check("s1_data", 32'(s_data), 32'd0);
    cyc(.cv(1), .ct(0), .val(32'h1234));
    cyc();
    check("s1_clr_we", 32'(s_we), 32'd1);
    check("s1_clr_data", 32'(s_data), 32'(INV));
    check("s1_cv", 32'(b.commit_valid), 32'd1);
    check("s1_cdest", 32'(b.commit_dest), 32'd5);
    check("s1_cval", b.commit_value, 32'h1234);
    cyc();

    // newer producer keeps ownership: no clear
    do_reset();
    cyc(.iv(1), .hd(1), .d(3));
    cyc(.iv(1), .hd(1), .d(3));
    cyc(.cv(1), .ct(0), .val(32'hbeef));
    cyc();
    check("s2_no_clear", 32'(s_we), 32'd0);
    check("s2_cv", 32'(b.commit_valid), 32'd1);
    check("s2_ctag", 32'(b.commit_tag), 32'd0);
    cyc();

    // fill, full stall, wrap-around
    do_reset();
    for (int i = 0; i < 16; i++) cyc(.iv(1), .hd(1), .d(5'(i)));
    cyc(.iv(1), .hd(1), .d(20), .cv(1), .ct(0), .val(32'haa));
    check("s3_full", 32'(s_ready), 32'd0);
    cyc(.iv(1), .hd(1), .d(20));
    check("s3_full_commit_cycle", 32'(s_ready), 32'd0);
    check("s3_cv", 32'(b.commit_valid), 32'd1);
    cyc(.iv(1), .hd(1), .d(21));
    check("s3_ready", 32'(s_ready), 32'd1);
    check("s3_wrap_tag", 32'(s_tag), 32'd0);
    check("s3_wrap_data", 32'(s_data), 32'd0);
    cyc();

    // out-of-order completion, in-order commit
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(.iv(1), .hd(1), .d(5'(i)));
    cyc(.cv(1), .ct(2), .val(32'h22));
    cyc(.cv(1), .ct(1), .val(32'h11));
    cyc(.cv(1), .ct(0), .val(32'h00));
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("s4_order_v", 32'(b.commit_valid), 32'd1);
      check("s4_order_tag", 32'(b.commit_tag), 32'(i));
    end
    cyc();

    // clear vs issue to another register: stall one cycle
    do_reset();
    cyc(.iv(1), .hd(1), .d(4));
    cyc(.cv(1), .ct(0), .val(32'h44));
    cyc(.iv(1), .hd(1), .d(7));
    check("s5_idx", 32'(s_idx), 32'd7);
    check("s5_stall", 32'(b.commit_valid), 32'd0);
    cyc();
    check("s5_retry_idx", 32'(s_idx), 32'd4);
    check("s5_retry_data", 32'(s_data), 32'(INV));
    check("s5_cv", 32'(b.commit_valid), 32'd1);
    cyc();

    // clear vs issue to the same register: no stall
    do_reset();
    cyc(.iv(1), .hd(1), .d(4));
    cyc(.cv(1), .ct(0), .val(32'h45));
    cyc(.iv(1), .hd(1), .d(4));
    check("s6_idx", 32'(s_idx), 32'd4);
    check("s6_data", 32'(s_data), 32'd1);
    check("s6_cv", 32'(b.commit_valid), 32'd1);
    cyc();
    check("s6_no_clear", 32'(s_we), 32'd0);

    // flush
    do_reset();
    for (int i = 0; i < 5; i++) cyc(.iv(1), .hd(1), .d(5'(10 + i)));
    cyc(.iv(1), .hd(1), .d(15), .fl(1));
    check("s7_flush_we", 32'(s_we), 32'd0);
    check("s7_clear_all", 32'(b.stat_clear_all), 32'd1);
    check("s7_tag", 32'(b.issue_tag), 32'd0);
    cyc(.cv(1), .ct(2), .val(32'h77));
    check("s7_pulse_once", 32'(b.stat_clear_all), 32'd0);
    check("s7_no_commit", 32'(b.commit_valid), 32'd0);
    cyc();
    check("s7_no_commit2", 32'(b.commit_valid), 32'd0);
    cyc();

    // reset with entries in flight
    cyc(.iv(1), .hd(1), .d(9));
    cyc(.cv(1), .ct(0), .val(32'h99));
    do_reset();
    cyc();
    check("s8_no_commit", 32'(b.commit_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- 16-entry circular reorder buffer: the producer end of the register-status table protocol.
- At issue, allocates a ROB tag and writes it into the register-status table for the destination register.
- Captures CDB results, retires entries in program order, and writes the invalid tag (6'b010000) back to the table when the retiring entry is still the register's newest producer.
- Sits between issue logic, the CDB, the register-status table and the register file.

Parameters:
- DEPTH, 16, number of ROB entries; tags are 0..DEPTH-1.
- TAG_W, 4, tag width, log2(DEPTH).
- DATA_W, 32, result width.
- INVALID_TAG, 6'b010000, status-table value meaning "no pending producer".

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  issue request this cycle
- issue_has_dest  in  1  instruction writes a register
- issue_dest  in  5  destination register index
- issue_ready  out  1  ROB can accept an issue
- issue_tag  out  4  tag allocated to the accepted issue (current tail)
- stat_we  out  1  status-table write strobe
- stat_index  out  5  status-table register index
- stat_data  out  6  value written to the status table
- stat_query_index  out  5  register index looked up in the table (head entry's dest)
- stat_query_data  in  6  table contents for stat_query_index (combinational)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  4  tag of the broadcast result
- cdb_value  in  32  broadcast result
- flush  in  1  synchronous discard of all entries
- stat_clear_all  out  1  one-cycle pulse telling the table to reset every entry to INVALID_TAG
- commit_valid  out  1  one-cycle retire pulse
- commit_has_dest  out  1  retired entry writes a register
- commit_dest  out  5  register-file index
- commit_value  out  32  register-file data
- commit_tag  out  4  retired tag

Behaviour:
- State:
  - head, tail (TAG_W bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
  - Per entry: busy, done, has_dest, dest, value.
- Reset (async):
  - Pointers and count are 0; all busy/done are 0.
  - commit_* = 0, stat_we = 0, stat_index = 0, stat_data = INVALID_TAG, stat_clear_all = 0.
- Issue:
  - issue_ready = (count != DEPTH); it is evaluated on the pre-edge count, so no issue is accepted at full even when a commit occurs in the same cycle.
  - issue_tag = tail.
  - An issue is accepted when issue_valid & issue_ready. At the clock edge: entry[tail] gets busy=1, done=0, dest and has_dest loaded; tail advances.
- Status write, issue (combinational, same cycle as acceptance):
  - Applies when accepted and has_dest.
  - stat_we=1, stat_index=issue_dest, stat_data={2'b00,tail}.
- CDB capture:
  - On cdb_valid with entry[cdb_tag].busy=1: set done=1 and value=cdb_value at the edge.
  - Ignored if that entry is not busy, including a tag being allocated in the same cycle.
- Retire condition: entry[head].busy & done. stat_query_index = entry[head].dest at all times.
- Clear needed: retiring & has_dest & stat_query_data == {2'b00,head}.
- Write-port arbitration (single status write port):
  - Issue write only -> the issue write is driven.
  - Clear only -> stat_we=1, stat_index=head dest, stat_data=INVALID_TAG.
  - Issue write and clear to the same register -> the issue write wins, the clear is dropped, and retirement proceeds.
  - Issue write and clear to different registers -> the issue write wins and retirement stalls one cycle; head is unchanged and the clear is retried next cycle.
- Retire (when not stalled), at the edge:
  - Clear entry[head].busy; head advances.
  - Next cycle: commit_valid=1 with dest, value, has_dest and tag of the retired entry; otherwise commit_valid=0.
- Count: +1 on issue, -1 on retire, unchanged when both or neither occur.
- Flush:
  - At the edge: all busy=0, head=tail=count=0; stat_clear_all=1 for the following cycle.
  - Issue, CDB capture and retire in the flush cycle are discarded.
  - Flush has priority over everything except rst.
- Reset mid-operation: all in-flight entries are dropped immediately; no commit pulse is produced.

Test Plan:
- Reset, then issue r5 -> issue_tag=0, stat_we=1, stat_index=5, stat_data=6'b000000 in the same cycle. CDB tag0 value 0x1234 with stat_query_data=0 -> next cycle commit_valid=1, commit_dest=5, commit_value=0x1234, then a clear write (stat_data=6'b010000).
- Issue r3 twice (tags 0, 1) with the table returning 1 for r3; complete tag0 -> commit tag0 with no clear write (r3 stays owned by tag 1).
- Issue 16 entries -> issue_ready=0 with count=16. Commit one and hold issue_valid -> no accept that cycle, accepted the next; the 17th issue gets tag 0 (wrap-around).
- Complete tags 2, 1, 0 out of order on the CDB -> commits emerge in order 0, 1, 2 on consecutive cycles.
- Head on r4 needs a clear while r7 issues in the same cycle -> stat_index=7 and commit is delayed one cycle, then the clear to r4 appears. Repeat with issue to r4 -> no clear and no stall.
- Fill 5 entries, assert flush -> stat_clear_all pulses once, count=0, issue_tag=0; a later CDB on an old tag causes no commit.
